lc3_control: RTL and testbench
==============================

# lc3_control

Multicycle control unit for the 16-bit LC-3-style datapath. Sequences fetch, decode and execute for a subset of LC-3 instructions and drives every load/gate/select strobe, including the register file's DR, SR1, SR2 and regWE. Sits directly upstream of the register file, ALU and memory interface. Consumes IR and the condition-code flags. Also keeps a retired-instruction counter.

## Interface
- No parameters; all encodings are fixed constants in lc3_pkg.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- IR  in  16  current instruction register contents.
- nzp  in  3  condition codes {N,Z,P} from the CC register.
- ldPC, ldIR, ldMAR, ldMDR, ldCC  out  1 each  register load enables.
- gatePC, gateMDR, gateALU, gateMARMUX  out  1 each  Buss drivers; at most one high per cycle.
- regWE  out  1  register-file write enable.
- DR, SR1, SR2  out  3 each  register-file addresses.
- aluControl  out  2  00 PASS(Ra), 01 ADD, 10 AND, 11 NOT.
- selPC  out  2  00 PC+1, 01 address adder, 10 Buss.
- selEAB1  out  1  0 PC, 1 Ra.
- selEAB2  out  2  00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0]).
- selMDR  out  1  0 Buss, 1 memory read data.
- memWE  out  1  memory write strobe.
- halted  out  1  high in HALT.
- instrCount  out  16  instructions loaded into IR since reset.

## Operation
- States: FETCH0, FETCH1, FETCH2, DECODE, EXEC_ALU, EXEC_LEA, EXEC_BR, EXEC_JMP, LD0, LD1, LD2, ST0, ST1, ST2, HALT.
- FETCH0: gatePC, ldMAR, ldPC, selPC=00. FETCH1: ldMDR, selMDR=1. FETCH2: gateMDR, ldIR, instrCount+1. DECODE: no strobes.
- Register addresses outside ST: DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0]. In ST1, SR1=IR[11:9].
- DECODE dispatch on IR[15:12]:
  - 0001/0101/1001 → EXEC_ALU.
  - 1110 → EXEC_LEA.
  - 0000 → EXEC_BR if (IR[11:9] & nzp)≠0, else FETCH0.
  - 1100 → EXEC_JMP.
  - 0010 → LD0. 0011 → ST0. 1111 → HALT.
  - Any other opcode → FETCH0, treated as a NOP.
- EXEC_ALU: gateALU, regWE, ldCC, aluControl=ADD/AND/NOT per opcode.
- EXEC_LEA: selEAB1=0, selEAB2=10, gateMARMUX, regWE, ldCC.
- EXEC_BR: selEAB1=0, selEAB2=10, selPC=01, ldPC.
- EXEC_JMP: selEAB1=1, selEAB2=00, selPC=01, ldPC.
- LD0 and ST0: selEAB1=0, selEAB2=10, gateMARMUX, ldMAR.
- LD1: ldMDR, selMDR=1. LD2: gateMDR, regWE, ldCC.
- ST1: aluControl=PASS, gateALU, ldMDR, selMDR=0. ST2: memWE.
- Every EXEC_*, LD2 and ST2 returns to FETCH0.
- HALT is absorbing: no strobes, halted=1, exit only via reset.
- Strobe defaults: any strobe not listed for a state is 0. DR/SR fields are don't-care when regWE=0.

## Timing
- All outputs are Moore: decoded from the registered state and IR.
- While reset is low, every output is 0, state=FETCH0 and instrCount=0.
- First FETCH0 strobes appear in the first cycle after reset rises.
- Cycles per instruction, fetch included:
  - ALU/LEA/JMP/taken BR: 5.
  - Untaken BR and illegal opcodes: 4.
  - LD and ST: 7.
- instrCount wraps 0xFFFF→0x0000 with no flag.
- Reset asserted mid-instruction aborts it immediately and asynchronously. No partial regWE or memWE after reset assertion.
- IR must be stable from FETCH2 until the next FETCH0; the block does not latch it.

## Structure
- lc3_pkg holds:
  - opcode constants;
  - state enum;
  - aluControl, selPC, selEAB2 and selMDR encodings.
- One sub-module, lc3_out_decode: combinational state+IR → strobe decode. lc3_control keeps the state register, the next-state logic and instrCount.

## Test plan
- Release reset; observe FETCH0 strobes (gatePC=1, ldMAR=1, ldPC=1), then FETCH1 and FETCH2, with instrCount 0→1 at the FETCH2 edge.
- IR=0x1283 (ADD R1,R2,R3): EXEC_ALU in cycle 5 shows regWE=1, DR=1, SR1=2, SR2=3, aluControl=01, ldCC=1.
- IR=0x0405 (BRz): nzp=010 → EXEC_BR with ldPC=1, selPC=01. nzp=100 → DECODE goes straight to FETCH0 with no ldPC.
- IR=0x3A10 (ST R5): ST1 shows SR1=5, gateALU=1, ldMDR=1. ST2 shows memWE=1 for exactly one cycle.
- IR=0x2A10 (LD): pull reset low during LD1. All outputs 0 at once, no regWE, instrCount=0, FETCH0 after release.
- IR=0xF025 reaches HALT and stays there with halted=1 for 100 cycles. IR=0xD000 (illegal) returns to FETCH0 after 4 cycles.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared encodings for the lc3_control block
// Purpose: opcode constants, FSM state encoding and the select/ALU codes
//          driven onto the datapath, plus the branch-condition helper.
// Ports:   none (package).
package lc3_pkg;

  // Opcodes (IR[15:12]) that the control unit understands
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH0   = 4'd0;
  localparam state_t S_FETCH1   = 4'd1;
  localparam state_t S_FETCH2   = 4'd2;
  localparam state_t S_DECODE   = 4'd3;
  localparam state_t S_EXEC_ALU = 4'd4;
  localparam state_t S_EXEC_LEA = 4'd5;
  localparam state_t S_EXEC_BR  = 4'd6;
  localparam state_t S_EXEC_JMP = 4'd7;
  localparam state_t S_LD0      = 4'd8;
  localparam state_t S_LD1      = 4'd9;
  localparam state_t S_LD2      = 4'd10;
  localparam state_t S_ST0      = 4'd11;
  localparam state_t S_ST1      = 4'd12;
  localparam state_t S_ST2      = 4'd13;
  localparam state_t S_HALT     = 4'd14;

  // aluControl
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  // selPC
  localparam logic [1:0] SELPC_INC  = 2'b00;
  localparam logic [1:0] SELPC_ADDR = 2'b01;
  localparam logic [1:0] SELPC_BUS  = 2'b10;

  // selEAB1 / selEAB2
  localparam logic       EAB1_PC    = 1'b0;
  localparam logic       EAB1_RA    = 1'b1;
  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  // selMDR
  localparam logic SELMDR_BUS = 1'b0;
  localparam logic SELMDR_MEM = 1'b1;

  // A branch is taken when any requested condition (IR[11:9]) matches the CCs
  function automatic logic br_taken(input logic [2:0] cond, input logic [2:0] nzp);
    return (cond & nzp) != 3'b000;
  endfunction

endpackage

// File: rtl/lc3_out_decode.sv
// rtl/lc3_out_decode.sv - Moore decode of FSM state and IR into datapath strobes
// Purpose: purely combinational; every strobe defaults to 0 and is forced to 0
//          while active_i is low so reset masks all outputs immediately.
// Ports:   active_i, state_i, op_i/ir_11_9_i/ir_8_6_i/ir_2_0_i (IR fields) in;
//          load/gate/select strobes, register addresses, memWE, halted out.
import lc3_pkg::*;

module lc3_out_decode (
  input  logic       active_i,
  input  state_t     state_i,
  input  logic [3:0] op_i,
  input  logic [2:0] ir_11_9_i,
  input  logic [2:0] ir_8_6_i,
  input  logic [2:0] ir_2_0_i,
  output logic       ld_pc_o,
  output logic       ld_ir_o,
  output logic       ld_mar_o,
  output logic       ld_mdr_o,
  output logic       ld_cc_o,
  output logic       gate_pc_o,
  output logic       gate_mdr_o,
  output logic       gate_alu_o,
  output logic       gate_marmux_o,
  output logic       reg_we_o,
  output logic [2:0] dr_o,
  output logic [2:0] sr1_o,
  output logic [2:0] sr2_o,
  output logic [1:0] alu_control_o,
  output logic [1:0] sel_pc_o,
  output logic       sel_eab1_o,
  output logic [1:0] sel_eab2_o,
  output logic       sel_mdr_o,
  output logic       mem_we_o,
  output logic       halted_o
);

  always_comb begin
    ld_pc_o       = 1'b0;
    ld_ir_o       = 1'b0;
    ld_mar_o      = 1'b0;
    ld_mdr_o      = 1'b0;
    ld_cc_o       = 1'b0;
    gate_pc_o     = 1'b0;
    gate_mdr_o    = 1'b0;
    gate_alu_o    = 1'b0;
    gate_marmux_o = 1'b0;
    reg_we_o      = 1'b0;
    dr_o          = 3'b000;
    sr1_o         = 3'b000;
    sr2_o         = 3'b000;
    alu_control_o = ALU_PASS;
    sel_pc_o      = SELPC_INC;
    sel_eab1_o    = EAB1_PC;
    sel_eab2_o    = EAB2_ZERO;
    sel_mdr_o     = SELMDR_BUS;
    mem_we_o      = 1'b0;
    halted_o      = 1'b0;

    if (active_i) begin
      dr_o  = ir_11_9_i;
      sr1_o = ir_8_6_i;
      sr2_o = ir_2_0_i;

      case (state_i)
        S_FETCH0: begin
          gate_pc_o = 1'b1;
          ld_mar_o  = 1'b1;
          ld_pc_o   = 1'b1;
        end
        S_FETCH1: begin
          ld_mdr_o  = 1'b1;
          sel_mdr_o = SELMDR_MEM;
        end
        S_FETCH2: begin
          gate_mdr_o = 1'b1;
          ld_ir_o    = 1'b1;
        end
        S_EXEC_ALU: begin
          gate_alu_o = 1'b1;
          reg_we_o   = 1'b1;
          ld_cc_o    = 1'b1;
          case (op_i)
            OP_ADD:  alu_control_o = ALU_ADD;
            OP_AND:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_NOT;
          endcase
        end
        S_EXEC_LEA: begin
          sel_eab2_o    = EAB2_OFF9;
          gate_marmux_o = 1'b1;
          reg_we_o      = 1'b1;
          ld_cc_o       = 1'b1;
        end
        S_EXEC_BR: begin
          sel_eab2_o = EAB2_OFF9;
          sel_pc_o   = SELPC_ADDR;
          ld_pc_o    = 1'b1;
        end
        S_EXEC_JMP: begin
          sel_eab1_o = EAB1_RA;
          sel_pc_o   = SELPC_ADDR;
          ld_pc_o    = 1'b1;
        end
        S_LD0, S_ST0: begin
          sel_eab2_o    = EAB2_OFF9;
          gate_marmux_o = 1'b1;
          ld_mar_o      = 1'b1;
        end
        S_LD1: begin
          ld_mdr_o  = 1'b1;
          sel_mdr_o = SELMDR_MEM;
        end
        S_LD2: begin
          gate_mdr_o = 1'b1;
          reg_we_o   = 1'b1;
          ld_cc_o    = 1'b1;
        end
        S_ST1: begin
          // The store source register sits in the DR field; route it through
          // SR1 so the ALU can pass it onto the bus.
          sr1_o         = ir_11_9_i;
          alu_control_o = ALU_PASS;
          gate_alu_o    = 1'b1;
          ld_mdr_o      = 1'b1;
          sel_mdr_o     = SELMDR_BUS;
        end
        S_ST2: begin
          mem_we_o = 1'b1;
        end
        S_HALT: begin
          halted_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lc3_control.sv
// rtl/lc3_control.sv - multicycle fetch/decode/execute controller for the LC-3 subset
// Purpose: holds the FSM state register, next-state dispatch and the
//          retired-instruction counter; strobes come from lc3_out_decode.
// Ports:   clk, reset (async active-low), IR[15:0], nzp[2:0] in;
//          ld*/gate* strobes, regWE, DR/SR1/SR2, aluControl, selPC, selEAB1,
//          selEAB2, selMDR, memWE, halted, instrCount[15:0] out.
import lc3_pkg::*;

module lc3_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic [2:0]  nzp,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        ldCC,
  output logic        gatePC,
  output logic        gateMDR,
  output logic        gateALU,
  output logic        gateMARMUX,
  output logic        regWE,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [1:0]  aluControl,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMDR,
  output logic        memWE,
  output logic        halted,
  output logic [15:0] instrCount
);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;

  // IR[5:3] (SR2 vs. immediate mode) only matters to the datapath
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[5:3];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          OP_ADD, OP_AND, OP_NOT: state_d = S_EXEC_ALU;
          OP_LEA:  state_d = S_EXEC_LEA;
          OP_BR:   state_d = br_taken(IR[11:9], nzp) ? S_EXEC_BR : S_FETCH0;
          OP_JMP:  state_d = S_EXEC_JMP;
          OP_LD:   state_d = S_LD0;
          OP_ST:   state_d = S_ST0;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH0;  // unsupported opcode acts as a NOP
        endcase
      end
      S_LD0:    state_d = S_LD1;
      S_LD1:    state_d = S_LD2;
      S_ST0:    state_d = S_ST1;
      S_ST1:    state_d = S_ST2;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH0;  // EXEC_*, LD2, ST2 and unused encodings
    endcase
  end

  // Counts on the edge that loads IR; wraps silently
  always_comb begin
    count_d = count_q;
    if (state_q == S_FETCH2) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign instrCount = count_q;

  // Outputs are masked directly by reset so nothing strobes during reset,
  // even though the state register already holds FETCH0.
  lc3_out_decode u_out_decode (
    .active_i      (reset),
    .state_i       (state_q),
    .op_i          (IR[15:12]),
    .ir_11_9_i     (IR[11:9]),
    .ir_8_6_i      (IR[8:6]),
    .ir_2_0_i      (IR[2:0]),
    .ld_pc_o       (ldPC),
    .ld_ir_o       (ldIR),
    .ld_mar_o      (ldMAR),
    .ld_mdr_o      (ldMDR),
    .ld_cc_o       (ldCC),
    .gate_pc_o     (gatePC),
    .gate_mdr_o    (gateMDR),
    .gate_alu_o    (gateALU),
    .gate_marmux_o (gateMARMUX),
    .reg_we_o      (regWE),
    .dr_o          (DR),
    .sr1_o         (SR1),
    .sr2_o         (SR2),
    .alu_control_o (aluControl),
    .sel_pc_o      (selPC),
    .sel_eab1_o    (selEAB1),
    .sel_eab2_o    (selEAB2),
    .sel_mdr_o     (selMDR),
    .mem_we_o      (memWE),
    .halted_o      (halted)
  );

endmodule

// File: tb/tb_lc3_control.sv
// tb/tb_lc3_control.sv - self-checking bench for lc3_control
module tb_lc3_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR;
  logic [2:0]  nzp;
  logic        ldPC, ldIR, ldMAR, ldMDR, ldCC;
  logic        gatePC, gateMDR, gateALU, gateMARMUX, regWE;
  logic [2:0]  DR, SR1, SR2;
  logic [1:0]  aluControl, selPC, selEAB2;
  logic        selEAB1, selMDR, memWE, halted;
  logic [15:0] instrCount;

  always #5 clk = ~clk;

  lc3_control dut (
    .clk(clk), .reset(reset), .IR(IR), .nzp(nzp),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldCC(ldCC),
    .gatePC(gatePC), .gateMDR(gateMDR), .gateALU(gateALU), .gateMARMUX(gateMARMUX),
    .regWE(regWE), .DR(DR), .SR1(SR1), .SR2(SR2), .aluControl(aluControl),
    .selPC(selPC), .selEAB1(selEAB1), .selEAB2(selEAB2), .selMDR(selMDR),
    .memWE(memWE), .halted(halted), .instrCount(instrCount)
  );

  typedef struct packed {
    logic ldPC, ldIR, ldMAR, ldMDR, ldCC;
    logic gatePC, gateMDR, gateALU, gateMARMUX, regWE;
    logic [1:0] aluControl;
    logic [1:0] selPC;
    logic selEAB1;
    logic [1:0] selEAB2;
    logic selMDR, memWE, halted;
  } strobes_t;

  typedef struct packed {
    strobes_t   s;
    logic       c_dr, c_sr1, c_sr2;
    logic [2:0] dr, sr1, sr2;
  } step_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          cycles;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  step_t       exp_q[$];

  function automatic strobes_t observed();
    strobes_t o;
    o = '{ldPC:ldPC, ldIR:ldIR, ldMAR:ldMAR, ldMDR:ldMDR, ldCC:ldCC,
          gatePC:gatePC, gateMDR:gateMDR, gateALU:gateALU, gateMARMUX:gateMARMUX,
          regWE:regWE, aluControl:aluControl, selPC:selPC, selEAB1:selEAB1,
          selEAB2:selEAB2, selMDR:selMDR, memWE:memWE, halted:halted};
    return o;
  endfunction

  // Reference: the instruction's micro-step list, written from the
  // instruction semantics (fetch, decode, then per-class execute steps).
  function automatic void model(input logic [15:0] ir, input logic [2:0] n);
    step_t st;
    logic [3:0] op;
    op = ir[15:12];
    exp_q.delete();
    st = '0; st.s.gatePC = 1; st.s.ldMAR = 1; st.s.ldPC = 1;       exp_q.push_back(st);
    st = '0; st.s.ldMDR = 1; st.s.selMDR = 1;                       exp_q.push_back(st);
    st = '0; st.s.gateMDR = 1; st.s.ldIR = 1;                       exp_q.push_back(st);
    st = '0;                                                        exp_q.push_back(st);
    st = '0;
    if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      st.s.gateALU = 1; st.s.regWE = 1; st.s.ldCC = 1;
      st.s.aluControl = (op == 4'h1) ? 2'd1 : (op == 4'h5) ? 2'd2 : 2'd3;
      st.c_dr = 1; st.c_sr1 = 1; st.c_sr2 = 1;
      st.dr = ir[11:9]; st.sr1 = ir[8:6]; st.sr2 = ir[2:0];
      exp_q.push_back(st);
    end else if (op == 4'hE) begin
      st.s.selEAB2 = 2'd2; st.s.gateMARMUX = 1; st.s.regWE = 1; st.s.ldCC = 1;
      st.c_dr = 1; st.dr = ir[11:9];
      exp_q.push_back(st);
    end else if (op == 4'h0) begin
      if ((ir[11:9] & n) != 0) begin
        st.s.selEAB2 = 2'd2; st.s.selPC = 2'd1; st.s.ldPC = 1;
        exp_q.push_back(st);
      end
    end else if (op == 4'hC) begin
      st.s.selEAB1 = 1; st.s.selPC = 2'd1; st.s.ldPC = 1;
      exp_q.push_back(st);
    end else if (op == 4'h2 || op == 4'h3) begin
      st.s.selEAB2 = 2'd2; st.s.gateMARMUX = 1; st.s.ldMAR = 1;
      exp_q.push_back(st);
      st = '0;
      if (op == 4'h2) begin
        st.s.ldMDR = 1; st.s.selMDR = 1;                            exp_q.push_back(st);
        st = '0; st.s.gateMDR = 1; st.s.regWE = 1; st.s.ldCC = 1;
        st.c_dr = 1; st.dr = ir[11:9];                              exp_q.push_back(st);
      end else begin
        st.s.gateALU = 1; st.s.ldMDR = 1; st.c_sr1 = 1; st.sr1 = ir[11:9];
        exp_q.push_back(st);
        st = '0; st.s.memWE = 1;                                    exp_q.push_back(st);
      end
    end else if (op == 4'hF) begin
      st.s.halted = 1;
      exp_q.push_back(st);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_step(input string name, input step_t e);
    chk({name, "_strobes"}, 32'(observed()), 32'(e.s));
    if (e.c_dr)  chk({name, "_DR"}, 32'(DR), 32'(e.dr));
    if (e.c_sr1) chk({name, "_SR1"}, 32'(SR1), 32'(e.sr1));
    if (e.c_sr2) chk({name, "_SR2"}, 32'(SR2), 32'(e.sr2));
  endtask

  // Entered on a falling edge with the DUT in FETCH0; returns on the falling
  // edge where the next FETCH0 is visible.
  task automatic run_instr(input logic [15:0] ir, input logic [2:0] n, output int cyc);
    model(ir, n);
    IR = ir; nzp = n; cyc = 0;
    do begin
      #1;
      if (cyc < exp_q.size()) check_step($sformatf("ir%h_c%0d", ir, cyc), exp_q[cyc]);
      if (cyc == 2) chk("count_fetch2", 32'(instrCount), 32'(exp_cnt));
      if (cyc == 3) chk("count_decode", 32'(instrCount), 32'(exp_cnt + 16'd1));
      @(posedge clk); @(negedge clk);
      cyc++;
    end while (!gatePC && cyc < 12);
    exp_cnt = exp_cnt + 16'd1;
    chk($sformatf("ir%h_len", ir), 32'(cyc), 32'(exp_q.size()));
  endtask

  vec_t tbl[15];

  initial begin
    int cyc;
    int bad;
    tbl = '{
      '{16'h1283, 3'b000, 5}, '{16'h0405, 3'b010, 5}, '{16'h0405, 3'b100, 4},
      '{16'h3A10, 3'b001, 7}, '{16'h2A10, 3'b010, 7}, '{16'hD000, 3'b111, 4},
      '{16'h5AC2, 3'b001, 5}, '{16'h967F, 3'b100, 5}, '{16'hE1FF, 3'b010, 5},
      '{16'hC1C0, 3'b000, 5}, '{16'h0E00, 3'b001, 5}, '{16'h0000, 3'b111, 4},
      '{16'h4000, 3'b000, 4}, '{16'h8123, 3'b000, 4}, '{16'hB000, 3'b010, 4}
    };

    reset = 1'b0; IR = 16'h1283; nzp = 3'b111;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_strobes", 32'(observed()), 32'd0);
    chk("reset_regs", 32'({DR, SR1, SR2}), 32'd0);
    chk("reset_count", 32'(instrCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].ir, tbl[i].nzp, cyc);
      chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cycles));
    end

    for (int i = 0; i < 300; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (r[15:12] == 4'hF) r[15:12] = 4'h1;
      run_instr(r, 3'($urandom), cyc);
    end

    // Reset in LD1: outputs drop at once, counter clears, fetch restarts
    model(16'h2A10, 3'b000);
    IR = 16'h2A10;
    for (int k = 0; k < 6; k++) begin
      #1 check_step($sformatf("ldrst_c%0d", k), exp_q[k]);
      if (k < 5) begin @(posedge clk); @(negedge clk); end
    end
    reset = 1'b0;
    #1;
    chk("ldrst_strobes", 32'(observed()), 32'd0);
    chk("ldrst_count", 32'(instrCount), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("ldrst_hold", 32'({observed(), DR, SR1, SR2}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 16'd0;
    run_instr(16'h1283, 3'b000, cyc);
    chk("after_reset_cycles", 32'(cyc), 32'd5);

    // HALT is absorbing
    model(16'hF025, 3'b000);
    IR = 16'hF025;
    for (int k = 0; k < 4; k++) begin
      #1 check_step($sformatf("halt_c%0d", k), exp_q[k]);
      @(posedge clk); @(negedge clk);
    end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (observed() !== exp_q[4].s) bad++;
      @(posedge clk); @(negedge clk);
    end
    chk("halt_stays", 32'(bad), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(instrCount), 32'(exp_cnt + 16'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
